// File: rtl/datapath_exec.sv
// Register-and-ALU datapath executing the per-cycle X/Y/Z and ULA command words from the sequencer.
// Returns the Z-load count so the sequencer can decide when its loop is done.
module datapath_exec #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] entrada,
    input  logic [4:0]       tx,
    input  logic [4:0]       ty,
    input  logic [4:0]       tz,
    input  logic [4:0]       tula,
    output logic [WIDTH-1:0] rx,
    output logic [WIDTH-1:0] ry,
    output logic [WIDTH-1:0] rz,
    output logic [WIDTH-1:0] ula_out,
    output logic             carry,
    output logic             zero,
    output logic [4:0]       contador
);

    typedef enum logic [4:0] {
        CMD_CLEAR  = 5'd0,
        CMD_LOAD   = 5'd1,
        CMD_HOLD   = 5'd2,
        CMD_SHIFTL = 5'd3
    } regCmd_t;

    typedef enum logic [4:0] {
        ULA_ADD = 5'd0,
        ULA_SUB = 5'd1,
        ULA_AND = 5'd2,
        ULA_OR  = 5'd3
    } ulaOp_t;

    logic [WIDTH:0]   sumWide;
    logic             ulaCarry;
    logic [WIDTH-1:0] nextX;
    logic [WIDTH-1:0] nextY;
    logic [WIDTH-1:0] nextZ;
    logic             nextCarry;
    logic [4:0]       nextContador;

    // Codes outside the defined set fall to the default arm and act as HOLD.
    function automatic logic [WIDTH-1:0] applyCmd(
        input logic [4:0]       cmd,
        input logic [WIDTH-1:0] current,
        input logic [WIDTH-1:0] loadValue
    );
        logic [WIDTH-1:0] result;
        case (cmd)
            CMD_CLEAR:  result = '0;
            CMD_LOAD:   result = loadValue;
            CMD_SHIFTL: result = {current[WIDTH-2:0], 1'b0};
            default:    result = current;
        endcase
        return result;
    endfunction

    // Combinational ULA; the carry it produces is only captured on a Y load.
    always_comb begin
        sumWide  = {1'b0, rx} + {1'b0, ry};
        ula_out  = rx;
        ulaCarry = 1'b0;
        case (tula)
            ULA_ADD: begin
                ula_out  = sumWide[WIDTH-1:0];
                ulaCarry = sumWide[WIDTH];
            end
            ULA_SUB: begin
                ula_out  = rx - ry;
                ulaCarry = (rx < ry);
            end
            ULA_AND: ula_out = rx & ry;
            ULA_OR:  ula_out = rx | ry;
            default: ula_out = rx;
        endcase
    end

    // All sources are pre-edge values, so simultaneous commands behave like independent registers.
    always_comb begin
        nextX        = applyCmd(tx, rx, entrada);
        nextY        = applyCmd(ty, ry, ula_out);
        nextZ        = applyCmd(tz, rz, ry);
        nextCarry    = (ty == CMD_LOAD) ? ulaCarry : carry;
        nextContador = (tz == CMD_LOAD) ? contador + 5'd1 : contador;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx       <= '0;
            ry       <= '0;
            rz       <= '0;
            carry    <= 1'b0;
            zero     <= 1'b1;
            contador <= '0;
        end else begin
            rx       <= nextX;
            ry       <= nextY;
            rz       <= nextZ;
            carry    <= nextCarry;
            zero     <= (nextZ == '0);
            contador <= nextContador;
        end
    end

endmodule
